// File: rtl/cpu_pkg.sv
// Shared core package: memory access sizes, address-error exception codes and the
// load/store queue entry layout.
package cpu_pkg;

`ifndef CPU_EXC_ADEL
`define CPU_EXC_ADEL 5'h04
`endif
`ifndef CPU_EXC_ADES
`define CPU_EXC_ADES 5'h05
`endif

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [4:0] EXC_ADEL = `CPU_EXC_ADEL;
  localparam logic [4:0] EXC_ADES = `CPU_EXC_ADES;

  // Widest tag an entry can hold; per-instance TAG_W must not exceed it.
  localparam int unsigned LSQ_TAG_W = 8;

  typedef struct packed {
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [1:0]           size;
    logic                 wr;
    logic [LSQ_TAG_W-1:0] tag;
  } lsq_entry_t;

endpackage

// File: rtl/agu_addr_chk.sv
// Per-way virtual address add and alignment check (purely combinational).
module agu_addr_chk
  import cpu_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [1:0]  size,
  input  logic        wr,
  input  logic        unalign,
  output logic [31:0] vaddr,
  output logic        fault,
  output logic [4:0]  code
);

  assign vaddr = base + imm;
  assign code  = wr ? EXC_ADES : EXC_ADEL;

  always_comb begin
    fault = 1'b0;
    case (size)
      MEM_SIZE_H: fault = vaddr[0];
      // lwl/lwr/swl/swr address arbitrary bytes within a word
      MEM_SIZE_W: fault = (vaddr[1:0] != 2'b00) && !unalign;
      default:    fault = 1'b0;
    endcase
  end

endmodule

// File: rtl/agu_lsq.sv
// Multi-way address generation with an in-order request queue feeding the dcache.
// Optional AGU_LSQ_PERF_EN adds saturating perf counters perf_enq/perf_exc/perf_full_stall.
module agu_lsq
  import cpu_pkg::*;
#(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [ISSUE_W-1:0]         in_valid,
  output logic                       in_ready,
  input  logic [ISSUE_W*32-1:0]      in_base,
  input  logic [ISSUE_W*32-1:0]      in_imm,
  input  logic [ISSUE_W*32-1:0]      in_wdata,
  input  logic [ISSUE_W*2-1:0]       in_size,
  input  logic [ISSUE_W-1:0]         in_wr,
  input  logic [ISSUE_W-1:0]         in_unalign,
  input  logic [ISSUE_W*TAG_W-1:0]   in_tag,
  output logic                       exc_valid,
  output logic [4:0]                 exc_code,
  output logic [31:0]                exc_badva,
  output logic [TAG_W-1:0]           exc_tag,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [31:0]                req_addr,
  output logic [31:0]                req_wdata,
  output logic [1:0]                 req_size,
  output logic                       req_wr,
  output logic [TAG_W-1:0]           req_tag,
  output logic [$clog2(DEPTH):0]     occupancy
`ifdef AGU_LSQ_PERF_EN
  ,
  output logic [31:0]                perf_enq,
  output logic [31:0]                perf_exc,
  output logic [31:0]                perf_full_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lsq_entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   exc_valid_q;
  logic [4:0]             exc_code_q;
  logic [31:0]            exc_badva_q;
  logic [TAG_W-1:0]       exc_tag_q;

  lsq_entry_t             way_entry [ISSUE_W];
  logic [31:0]            way_vaddr [ISSUE_W];
  logic [4:0]             way_code  [ISSUE_W];
  logic [ISSUE_W-1:0]     way_fault;

  lsq_entry_t             enq_ent [ISSUE_W];
  logic [CNT_W-1:0]       enq_cnt;
  logic                   accept, deq, exc_hit;
  logic [4:0]             exc_code_d;
  logic [31:0]            exc_badva_d;
  logic [TAG_W-1:0]       exc_tag_d;
  lsq_entry_t             head;

  for (genvar w = 0; w < ISSUE_W; w++) begin : g_way
    agu_addr_chk u_chk (
      .base    (in_base[w*32 +: 32]),
      .imm     (in_imm[w*32 +: 32]),
      .size    (in_size[w*2 +: 2]),
      .wr      (in_wr[w]),
      .unalign (in_unalign[w]),
      .vaddr   (way_vaddr[w]),
      .fault   (way_fault[w]),
      .code    (way_code[w])
    );
    assign way_entry[w] = '{addr:  way_vaddr[w],
                            wdata: in_wdata[w*32 +: 32],
                            size:  in_size[w*2 +: 2],
                            wr:    in_wr[w],
                            tag:   LSQ_TAG_W'(in_tag[w*TAG_W +: TAG_W])};
  end

  // Registered count only: a same-cycle pop does not open the gate.
  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ISSUE_W);
  assign accept   = in_ready && (|in_valid) && !flush;
  assign req_valid = count_q != '0;
  assign deq      = req_valid && req_ready;

  // Compact legal ways ahead of the oldest fault; everything after it is dropped.
  always_comb begin
    int unsigned n;
    logic        seen;
    n           = 0;
    seen        = 1'b0;
    exc_hit     = 1'b0;
    exc_code_d  = '0;
    exc_badva_d = '0;
    exc_tag_d   = '0;
    for (int i = 0; i < ISSUE_W; i++) enq_ent[i] = '0;
    if (accept) begin
      for (int w = 0; w < ISSUE_W; w++) begin
        if (in_valid[w] && !seen) begin
          if (way_fault[w]) begin
            seen        = 1'b1;
            exc_hit     = 1'b1;
            exc_code_d  = way_code[w];
            exc_badva_d = way_vaddr[w];
            exc_tag_d   = in_tag[w*TAG_W +: TAG_W];
          end else begin
            enq_ent[n] = way_entry[w];
            n          = n + 1;
          end
        end
      end
    end
    enq_cnt = CNT_W'(n);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_W; i++) begin
      if (i < int'(enq_cnt)) mem_q[wr_ptr_q + PTR_W'(i)] <= enq_ent[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      exc_badva_q <= '0;
      exc_tag_q   <= '0;
    end else if (flush) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      exc_valid_q <= 1'b0;
    end else begin
      count_q     <= count_q + enq_cnt - CNT_W'(deq);
      wr_ptr_q    <= wr_ptr_q + PTR_W'(enq_cnt);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(deq);
      exc_valid_q <= exc_hit;
      if (exc_hit) begin
        exc_code_q  <= exc_code_d;
        exc_badva_q <= exc_badva_d;
        exc_tag_q   <= exc_tag_d;
      end
    end
  end

  // Payload is gated so an empty queue never exposes stale entries.
  assign head      = mem_q[rd_ptr_q];
  assign req_addr  = req_valid ? head.addr : '0;
  assign req_wdata = req_valid ? head.wdata : '0;
  assign req_size  = req_valid ? head.size : '0;
  assign req_wr    = req_valid && head.wr;
  assign req_tag   = req_valid ? TAG_W'(head.tag) : '0;
  assign occupancy = count_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_badva = exc_badva_q;
  assign exc_tag   = exc_tag_q;

`ifdef AGU_LSQ_PERF_EN
  logic [31:0] perf_enq_q, perf_exc_q, perf_stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_enq_q   <= '0;
      perf_exc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_enq_q <= (perf_enq_q > (32'hFFFF_FFFF - 32'(enq_cnt))) ? 32'hFFFF_FFFF
                                                                  : perf_enq_q + 32'(enq_cnt);
      if (exc_hit && perf_exc_q != 32'hFFFF_FFFF) perf_exc_q <= perf_exc_q + 32'd1;
      if ((|in_valid) && !in_ready && perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_enq        = perf_enq_q;
  assign perf_exc        = perf_exc_q;
  assign perf_full_stall = perf_stall_q;
`endif

endmodule

// File: doc/agu_lsq.md
Name: agu_lsq

Overview:
- Parametrised, pipelined address-generation unit with an in-order memory request queue, for the N-way issue MIPS core.
- Accepts up to ISSUE_W memory/cache-op instructions per cycle and computes vaddr = base + imm per way.
- Performs alignment checks, reports the oldest faulting op as an exception, and queues legal ops.
- Drives the dcache one request per cycle via valid/ready.

Parameters:
ISSUE_W, 2, issue ways per cycle; way 0 is oldest
DEPTH, 4, queue entries; power of 2, >= ISSUE_W
TAG_W, 6, per-op tag width (ROB/commit index)

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (exception/branch redirect)
in_valid  in  ISSUE_W  way carries a memory op
in_ready  out  1  all ways can be accepted this cycle
in_base  in  ISSUE_W*32  reg1 data per way
in_imm  in  ISSUE_W*32  sign-extended immediate per way
in_wdata  in  ISSUE_W*32  reg2 data (store data) per way
in_size  in  ISSUE_W*2  00 byte, 01 half, 10 word
in_wr  in  ISSUE_W  store
in_unalign  in  ISSUE_W  lwl/lwr/swl/swr (skip word check)
in_tag  in  ISSUE_W*TAG_W  op tag
exc_valid  out  1  one-cycle exception pulse
exc_code  out  5  AdEL=5'h04, AdES=5'h05
exc_badva  out  32  faulting vaddr
exc_tag  out  TAG_W  faulting op tag
req_valid  out  1  queue head valid
req_ready  in  1  dcache accepts head
req_addr  out  32  vaddr
req_wdata  out  32  store data
req_size  out  2  size
req_wr  out  1  store
req_tag  out  TAG_W  tag
occupancy  out  clog2(DEPTH)+1  entries held

Behaviour:
- Reset: queue empty; rd/wr pointers 0; all outputs 0 (req_valid=0, exc_valid=0, occupancy=0).
- in_ready = (DEPTH - occupancy) >= ISSUE_W.
  - Computed from registered count only; dequeue in the same cycle does not raise it.
- Handshake: a cycle is an accept when in_ready=1 and any in_valid is set.
- Alignment: half faults if vaddr[0]; word faults if vaddr[1:0]!=0 and !in_unalign; byte never faults.
  - Fault code is AdES if in_wr, else AdEL.
- Per accept, scan ways 0..ISSUE_W-1:
  - Valid non-faulting ways before the first fault are enqueued in way order (compacted, no holes).
  - The first faulting way is registered to exc_* (exc_valid high next cycle for exactly 1 cycle).
  - All ways after the first fault are dropped.
- Enqueue latency: 1 cycle. An entry written at edge k is visible at the head (req_valid) after edge k when the queue was empty. No bypass.
- Dequeue: on req_valid && req_ready, the head pops and rd_ptr increments.
- Simultaneous enqueue+dequeue: occupancy += enq_cnt - 1.
- Pointers: clog2(DEPTH) bits, natural wrap; full/empty derived from occupancy.
- flush:
  - At the next edge: queue emptied, pointers reset to 0, exc_valid cleared.
  - Inputs of the flush cycle are discarded.
  - A head handshake in the flush cycle counts as delivered (the dcache owns it).
- exc_valid has priority over nothing; it is independent of queue state. A second fault while exc_valid=1 overwrites (the pulse is repeated).
- resetn low mid-operation: immediate asynchronous clear of all state.

Optional Feature:
AGU_LSQ_PERF_EN
- Defined: adds 32-bit saturating counters and output ports perf_enq, perf_exc, perf_full_stall.
  - perf_enq: ops enqueued.
  - perf_exc: exceptions.
  - perf_full_stall: cycles with any in_valid && !in_ready.
  - Counters are cleared by resetn only, not by flush.
- Undefined: the ports and logic are absent; otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - lsq_entry_t struct (addr, wdata, size, wr, tag).
  - MEM_SIZE_B/H/W constants.
  - EXC_ADEL/EXC_ADES codes, reusing the existing exception macros.
- One natural sub-module, agu_addr_chk: combinational per-way address add and alignment check, instantiated ISSUE_W times.
- Queue and scan logic stay in agu_lsq.

Test Plan:
- Reset, then way0 lw base=0x1000 imm=4, way1 sw base=0x2000 imm=8 wdata=0xDEADBEEF, req_ready=1:
  - req 0x1004 (wr=0) is on req_* the cycle after accept; 0x2008 (wr=1, wdata=0xDEADBEEF) follows the next cycle; occupancy returns to 0.
- Way0 lh vaddr=0x3001, way1 lw vaddr=0x4000:
  - exc_valid pulse, code 0x04, badva 0x3001, tag=way0 tag; nothing enqueued.
- Way0 lw 0x5000, way1 sw vaddr 0x5002 (in_unalign=0):
  - 0x5000 enqueued; exc code 0x05, badva 0x5002. With in_unalign=1 both are enqueued and no exc.
- req_ready=0, fill with 2 accepts (DEPTH=4):
  - occupancy=4, in_ready=0; release req_ready → drains in order; in_ready rises once occupancy<=2.
- Occupancy=3 and head handshake concurrent with flush:
  - next cycle occupancy=0, req_valid=0; the handshaked head is not re-presented.
- Assert resetn low while the queue is non-empty:
  - all outputs 0 immediately (asynchronous), before the next clk edge.
